// File: rtl/sysid_uptime.sv
// sysid_uptime: second-generation system-ID slave on Avalon-MM.
// Returns build ID, build timestamp, a version/capability word and a
// byte-writable scratch register, plus a free-running uptime counter whose
// upper bits are snapshotted into a shadow register whenever the low word is
// read. This lets software assemble a consistent CNT_W-bit sample from two
// 32-bit reads. Reads have a fixed 1-cycle latency and are flagged by
// readdatavalid. There is no waitrequest.
module sysid_uptime #(
  parameter logic [31:0] ID           = 32'd0,
  parameter logic [31:0] TIMESTAMP    = 32'd1412490851,
  parameter int          CNT_W        = 64,
  parameter logic [31:0] SCRATCH_INIT = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  // Width of the counter bits above the low word (1..32).
  localparam int SH_W = CNT_W - 32;

  // Register map word addresses.
  localparam logic [2:0] A_ID      = 3'd0;
  localparam logic [2:0] A_TSTAMP  = 3'd1;
  localparam logic [2:0] A_VERSION = 3'd2;
  localparam logic [2:0] A_SCRATCH = 3'd3;
  localparam logic [2:0] A_CNT_LO  = 3'd4;
  localparam logic [2:0] A_CNT_HI  = 3'd5;

  // Version word: major 2, minor 3, low byte advertises the counter width.
  localparam logic [31:0] VERSION = {16'h0002, 8'd3, 8'(CNT_W)};

  // The shadow register holds counter[CNT_W-1:32], so the counter must be
  // wider than one word and the upper part must fit in one word.
  generate
    if (CNT_W < 33 || CNT_W > 64) begin : g_bad_cnt_w
      $error("sysid_uptime: CNT_W must be in 33..64");
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------
  // A write wins over a simultaneous read; the read is dropped entirely,
  // so it neither returns data nor takes a snapshot.
  logic w_rd_acc;
  logic w_wr_scratch;
  logic w_wr_clr;
  logic w_snap;

  assign w_rd_acc     = read & ~write;
  assign w_wr_scratch = write & (address == A_SCRATCH);
  assign w_wr_clr     = write & (address == A_CNT_LO);
  assign w_snap       = w_rd_acc & (address == A_CNT_LO);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] r_cnt;
  logic [SH_W-1:0]  r_shadow;
  logic [31:0]      r_scratch;
  logic [31:0]      r_rdata;
  logic             r_rvalid;
  logic [31:0]      w_rd_mux;

  // Uptime counter: free-runs and wraps naturally; a write to the low-word
  // address zeroes it so the following edge sees 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_wr_clr) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Shadow captures the upper counter bits from the same cycle the low word
  // is read, so the two reads always describe one sample. Reading the
  // shadow itself leaves it untouched.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow <= '0;
    end else if (w_wr_clr) begin
      r_shadow <= '0;
    end else if (w_snap) begin
      r_shadow <= r_cnt[CNT_W-1:32];
    end
  end

  // Scratch register with per-byte write enables.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_scratch <= SCRATCH_INIT;
    end else if (w_wr_scratch) begin
      for (int i = 0; i < 4; i++) begin
        if (byteenable[i]) begin
          r_scratch[8*i +: 8] <= writedata[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------
  // Select the register contents as they stand at the accepting edge;
  // counter reads therefore return the pre-increment value.
  always_comb begin
    w_rd_mux = 32'd0;
    case (address)
      A_ID:      w_rd_mux = ID;
      A_TSTAMP:  w_rd_mux = TIMESTAMP;
      A_VERSION: w_rd_mux = VERSION;
      A_SCRATCH: w_rd_mux = r_scratch;
      A_CNT_LO:  w_rd_mux = r_cnt[31:0];
      A_CNT_HI:  w_rd_mux = 32'(r_shadow);
      default:   w_rd_mux = 32'd0;
    endcase
  end

  // Registered response: data is forced to zero whenever it is not valid,
  // so the bus never carries stale values between pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata  <= 32'd0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_rd_acc;
      r_rdata  <= w_rd_acc ? w_rd_mux : 32'd0;
    end
  end

  assign readdata      = r_rdata;
  assign readdatavalid = r_rvalid;

endmodule
